// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider (signed/unsigned), start/ready responder.
// Optional DIV_HOLD_RESULT_EN: replays the cached result for a repeated identical request.
module div_radix2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    CALC,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic                  ready_q, ready_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic                  abort;
  logic                  accept;
  logic                  load;
  logic                  hit;
  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W-1:0]     rem_lo;
  logic                  qbit;
  logic [DATA_W-1:0]     rem_nxt, quo_nxt;
  logic [DATA_W-1:0]     q_fix, r_fix;

  assign abort  = flush | annul_i;
  assign accept = start_i & ~abort;

  assign a_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign b_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign a_mag = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag = b_neg ? -opdata2_i : opdata2_i;

  // rem_q[MSB] set means the shifted remainder exceeds 2^DATA_W, so it always beats the divisor
  assign rem_lo  = {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
  assign qbit    = rem_q[DATA_W-1] | (rem_lo >= dvs_q);
  assign rem_nxt = qbit ? (rem_lo - dvs_q) : rem_lo;
  assign quo_nxt = {dvd_q[DATA_W-2:0], qbit};

  assign q_fix = qneg_q ? -quo_nxt : quo_nxt;
  assign r_fix = rneg_q ? -rem_nxt : rem_nxt;

`ifdef DIV_HOLD_RESULT_EN
  logic              last_vld_q;
  logic [DATA_W-1:0] last_a_q, last_b_q;
  logic              last_s_q;

  assign hit = last_vld_q & (opdata1_i == last_a_q) & (opdata2_i == last_b_q)
             & (signed_div_i == last_s_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_vld_q <= 1'b0;
      last_a_q   <= '0;
      last_b_q   <= '0;
      last_s_q   <= 1'b0;
    end else if (abort) begin
      last_vld_q <= 1'b0;
    end else if (load) begin
      last_vld_q <= 1'b0;
      last_a_q   <= opdata1_i;
      last_b_q   <= opdata2_i;
      last_s_q   <= signed_div_i;
    end else if (ready_d) begin
      last_vld_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = 1'b0;
    result_d = result_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            state_d = DONE;
            ready_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      DIVZERO: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // dvd_q holds the dividend magnitude; re-applying its sign restores the raw dividend
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {(rneg_q ? -dvd_q : dvd_q), {DATA_W{1'b1}}};
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {r_fix, q_fix};
          end
        end
      end
      DONE: begin
        if (accept) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = (opdata2_i == '0) ? DIVZERO : CALC;
      cnt_d   = '0;
      rem_d   = '0;
      dvd_d   = a_mag;
      dvs_d   = b_mag;
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed self-checking bench for div_radix2; honours DIV_HOLD_RESULT_EN when defined.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic        ready;
  logic [63:0] result;

  int vectors     = 0;
  int miscompares = 0;

  div_radix2 #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (signed_div),
    .ready_o      (ready),
    .result_o     (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ticks until ready_o is seen; lat = cycles after the start cycle, 0 if never seen.
  task automatic wait_ready(output int lat, input logic scramble);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (scramble && k == 1) begin
        opdata1 = 32'hDEAD_BEEF;
        opdata2 = 32'h0000_0000;
      end
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int exp_lat, input logic [63:0] exp_res, input string tag);
    int lat;
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    wait_ready(lat, 1'b1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    start = 1'b0;
    tick();
    check({tag, " ready drop"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    int lat;
    int ready_cnt;

    rst = 1'b0; flush = 1'b0; annul = 1'b0; start = 1'b0;
    opdata1 = '0; opdata2 = '0; signed_div = 1'b0;
    tick(); tick();
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b1;
    tick();

    run(32'd100, 32'd7, 1'b0, 33, {32'h2, 32'hE}, "u100/7");

`ifdef DIV_HOLD_RESULT_EN
    tick(); tick();
    run(32'd100, 32'd7, 1'b0, 1, {32'h2, 32'hE}, "cached 100/7");
    run(32'd100, 32'd8, 1'b0, 33, {32'h4, 32'hC}, "u100/8");
`else
    tick(); tick();
    run(32'd100, 32'd7, 1'b0, 33, {32'h2, 32'hE}, "repeat 100/7");
`endif

    run(32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s-7/2");
    run(32'hFFFF_FFF9, 32'd2, 1'b0, 33, {32'h0000_0001, 32'h7FFF_FFFC}, "uFFFFFFF9/2");
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 33, {32'h0000_0001, 32'hFFFF_FFFD}, "s7/-2");
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'h0, 32'h8000_0000}, "smin/-1");
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 33, {32'h0, 32'hFFFF_FFFF}, "umax/1");
    run(32'h0000_1234, 32'd0, 1'b0, 2, {32'h0000_1234, 32'hFFFF_FFFF}, "div0");
    run(32'hFFFF_FFFB, 32'd0, 1'b1, 2, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "sdiv0");

    // flush mid-calculation: aborted op never signals ready
    opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    flush = 1'b1; start = 1'b0;
    tick();
    flush = 1'b0;
    ready_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready) ready_cnt++;
    end
    check("flush no ready", 64'(ready_cnt), 64'd0);
    run(32'd9, 32'd3, 1'b0, 33, {32'h0, 32'h3}, "u9/3 after flush");

    // annul during calculation behaves as flush
    opdata1 = 32'd60; opdata2 = 32'd4; start = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    annul = 1'b1; start = 1'b0;
    tick();
    annul = 1'b0;
    ready_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready) ready_cnt++;
    end
    check("annul no ready", 64'(ready_cnt), 64'd0);

    // back-to-back: start held through DONE with new operands
    opdata1 = 32'd50; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    wait_ready(lat, 1'b0);
    check("b2b first latency", 64'(lat), 64'd33);
    check("b2b first result", result, {32'h1, 32'h7});
    opdata1 = 32'd20; opdata2 = 32'd6;
    wait_ready(lat, 1'b0);
    check("b2b second latency", 64'(lat), 64'd33);
    check("b2b second result", result, {32'h2, 32'h3});
    start = 1'b0;
    tick();
    check("b2b ready drop", {63'd0, ready}, 64'd0);
    check("result held in idle", result, {32'h2, 32'h3});

    // reset mid-calculation
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0; start = 1'b0;
    tick();
    check("midreset ready", {63'd0, ready}, 64'd0);
    check("midreset result", result, 64'd0);
    rst = 1'b1;
    tick();
    run(32'd100, 32'd7, 1'b0, 33, {32'h2, 32'hE}, "u100/7 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Multi-cycle iterative radix-2 restoring divider for the execute stage.
- Responder side of the ALU's start/ready divide handshake. The ALU holds start_i high and stalls until ready_o, then latches the result into HI/LO.
- Supports signed and unsigned 32-bit division.
- Output packing: result_o[63:32] = remainder (HI), result_o[31:0] = quotient (LO).

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- flush  input  1  pipeline flush; aborts any operation in flight.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request; held high by the initiator until ready_o is seen.
- annul_i  input  1  cancel request; same effect as flush.
- signed_div_i  input  1  1 = signed division, 0 = unsigned.
- ready_o  output  1  result valid this cycle.
- result_o  output  2*DATA_W  {remainder, quotient}.

Behaviour:
- Reset (rst low at a clock edge): state IDLE, counter 0, ready_o 0, result_o 0.
- States: IDLE, DIVZERO, CALC, DONE.
- IDLE:
  - start_i=1 and flush=0 and annul_i=0: latch the sign flags and operand magnitudes. For signed operation, magnitude = two's-complement absolute value.
  - If divisor == 0, go to DIVZERO; otherwise go to CALC with counter=0 and partial remainder=0.
- CALC, one quotient bit per cycle:
  - Shift {rem, dvd} left by 1 and trial-subtract the divisor from rem.
  - If non-negative, keep the difference and set the quotient bit to 1; otherwise the bit is 0.
  - After 32 CALC cycles (counter==31), go to DONE.
- DIVZERO: one cycle, then DONE with quotient = all ones and remainder = dividend, unmodified.
- Sign fixup, applied on entry to DONE:
  - Quotient is negated iff signed and the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed gives q = 0x80000000 (wraps) and r = 0. No exception is raised; overflow is the ALU's concern.
- Latency: start_i sampled in IDLE at cycle N gives ready_o=1 at cycle N+33 (normal) or N+2 (divide by zero).
- DONE: ready_o=1 for exactly this cycle and result_o is valid.
  - Next cycle: if start_i=1, treat it as a new request, identical to IDLE acceptance.
  - Otherwise go to IDLE with ready_o=0.
  - result_o holds its last value in IDLE until the next DONE.
- flush or annul_i high in DIVZERO/CALC/DONE: next state IDLE, ready_o=0, result_o unchanged, no ready ever issued for the aborted op.
- flush has priority over start_i in the same cycle.
- Operand changes on opdata*_i after acceptance are ignored; operands are latched at start.
- ready_o is registered and never asserted outside DONE.

Optional Feature:
- Macro: DIV_HOLD_RESULT_EN.
- With it defined:
  - Keep a "last result valid" flag plus the last accepted opdata1_i/opdata2_i/signed_div_i.
  - In IDLE, a start_i whose operands and sign exactly match the last completed op goes straight to DONE: ready_o one cycle after start, cached result_o.
  - This covers the ALU re-requesting the same divide after an external stall drops start_i.
  - The flag clears on reset, flush, annul_i, or acceptance of a non-matching request.
- Without it: every request recomputes (full 33-cycle latency); no cache registers are synthesized.

Test Plan:
- Unsigned 100 / 7, start at cycle N -> ready_o=1 only at N+33, result_o = {0x00000002, 0x0000000E}.
- Signed 0xFFFFFFF9 (-7) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
- Unsigned 0xFFFFFFF9 / 2 -> result_o = {0x00000001, 0x7FFFFFFC}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Divisor 0, dividend 0x1234 -> ready at N+2, {0x00001234, 0xFFFFFFFF}.
- flush pulse at N+10 -> ready_o never asserts for that op. A new 9/3 request accepted afterwards -> {0, 3} at 33 cycles after its start.
- Back-to-back: start_i kept high through DONE with new operands 20/6 -> second ready exactly 33 cycles after the first, {2, 3}.
- Reset low mid-CALC -> next cycle ready_o=0 and result_o=0.
- With DIV_HOLD_RESULT_EN: repeat 100/7 after start_i drops for 3 cycles -> ready one cycle after start, same result. Repeat with 100/8 -> full 33 cycles, {4, 12}.
